int_issue_buffer: RTL and testbench

- In-order issue buffer. Holds integer-block micro-ops from dispatch and presents them one at a time to the execution unit on the int_instr valid/ready handshake.
- It is the sending end of the int_instr interface.
- It consumes the registered writeback-stage redirect (flush_valid/flush_robid) and discards every buffered op younger than the redirecting instruction.
- Sits between dispatch/rename and the execution-unit top level.

---
 rtl/int_issue_buffer_if.sv | 29 ++
 rtl/int_issue_buffer.sv | 91 +++++++++
 tb/tb_int_issue_buffer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_issue_buffer_if.sv
// Dispatch-side enqueue and execution-side int_instr handshakes of the
// integer issue buffer. The buffer uses master; its environment uses slave.
interface int_issue_buffer_if #(
    parameter int ROB_SIZE_LOG = 6,
    parameter int PAYLOAD_W    = 256
);
    logic                   enq_valid;
    logic                   enq_ready;
    logic [ROB_SIZE_LOG:0]  enq_robid;
    logic [PAYLOAD_W-1:0]   enq_payload;
    logic                   int_instr_valid;
    logic                   int_instr_ready;
    logic [ROB_SIZE_LOG:0]  int_robid;
    logic [PAYLOAD_W-1:0]   int_payload;

    modport master (
        input  enq_valid, enq_robid, enq_payload,
        output enq_ready,
        output int_instr_valid, int_robid, int_payload,
        input  int_instr_ready
    );

    modport slave (
        output enq_valid, enq_robid, enq_payload,
        input  enq_ready,
        input  int_instr_valid, int_robid, int_payload,
        output int_instr_ready
    );
endinterface

// File: rtl/int_issue_buffer.sv
// In-order integer issue buffer: circular queue between dispatch and the
// execution unit, with suffix kill on a writeback redirect.
module int_issue_buffer #(
    parameter int DEPTH        = 8,
    parameter int ROB_SIZE_LOG = 6,
    parameter int PAYLOAD_W    = 256
) (
    input  logic                     clock,
    input  logic                     reset_n,
    int_issue_buffer_if.master       bus,
    input  logic                     flush_valid,
    input  logic [ROB_SIZE_LOG:0]    flush_robid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = ROB_SIZE_LOG + 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [AW:0]           head_q, head_d;
    logic [AW:0]           tail_q, tail_d;
    logic [RW-1:0]         rob_q [DEPTH];
    logic [PAYLOAD_W-1:0]  pay_q [DEPTH];

    logic [RW-1:0]  head_rob;
    logic           head_kill;
    logic           enq_fire;
    logic           deq_fire;
    logic [AW:0]    surv;
    logic [AW-1:0]  idx;

    // Wrap bit flips each lap of the ROB, which inverts the index order.
    function automatic logic younger(input logic [RW-1:0] a,
                                     input logic [RW-1:0] b);
        if (a[RW-1] == b[RW-1])
            return a[RW-2:0] > b[RW-2:0];
        else
            return a[RW-2:0] < b[RW-2:0];
    endfunction

    assign head_rob  = rob_q[head_q[AW-1:0]];
    assign count     = tail_q - head_q;
    assign head_kill = flush_valid && younger(head_rob, flush_robid);

    assign bus.enq_ready       = reset_n && (count != FULL) && !flush_valid;
    assign bus.int_instr_valid = (count != '0) && !head_kill;
    assign bus.int_robid       = head_rob;
    assign bus.int_payload     = pay_q[head_q[AW-1:0]];

    assign enq_fire = bus.enq_valid && bus.enq_ready;
    assign deq_fire = bus.int_instr_valid && bus.int_instr_ready;

    // Killed entries form a suffix, so survivors are exactly head..head+surv-1.
    always_comb begin
        surv = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q[AW-1:0] + AW'(i);
            if (((AW+1)'(i) < count) && !younger(rob_q[idx], flush_robid))
                surv = surv + ONE;
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (deq_fire)
            head_d = head_q + ONE;
        if (flush_valid)
            tail_d = head_q + surv;
        else if (enq_fire)
            tail_d = tail_q + ONE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clock) begin
        if (enq_fire) begin
            rob_q[tail_q[AW-1:0]] <= bus.enq_robid;
            pay_q[tail_q[AW-1:0]] <= bus.enq_payload;
        end
    end
endmodule

// File: tb/tb_int_issue_buffer.sv
// Scoreboard bench for int_issue_buffer: directed enqueue/flush/reset
// sequences with a decoupled dequeue monitor.
module tb_int_issue_buffer;
    localparam int RSL = 6;
    localparam int PW  = 256;
    localparam int D   = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush_valid;
    logic [RSL:0] flush_robid;
    logic [3:0]  count;

    always #5 clock = ~clock;

    int_issue_buffer_if #(.ROB_SIZE_LOG(RSL), .PAYLOAD_W(PW)) bus();

    int_issue_buffer #(
        .DEPTH(D), .ROB_SIZE_LOG(RSL), .PAYLOAD_W(PW)
    ) u_dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .flush_valid (flush_valid),
        .flush_robid (flush_robid),
        .count       (count)
    );

    typedef struct packed {
        logic [RSL:0]  r;
        logic [PW-1:0] p;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    function automatic logic [PW-1:0] pay(input logic [RSL:0] r);
        logic [PW-1:0] v;
        v = '0;
        for (int k = 0; k < 8; k++)
            v[k*32 +: 32] = 32'hA500_0000 ^ (32'(r) << 8) ^ 32'(k * 17);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && bus.int_instr_valid && bus.int_instr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL deq_unexpected: got robid %0h expected none",
                         bus.int_robid);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.int_robid !== mon_e.r || bus.int_payload !== mon_e.p) begin
                    failures++;
                    $display("FAIL deq: got robid %0h payload %0h expected robid %0h payload %0h",
                             bus.int_robid, bus.int_payload, mon_e.r, mon_e.p);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_enq(input logic [RSL:0] r);
        bus.enq_valid   = 1'b1;
        bus.enq_robid   = r;
        bus.enq_payload = pay(r);
        exp_q.push_back(exp_t'{r: r, p: pay(r)});
    endtask

    task automatic enq_one(input logic [RSL:0] r);
        drive_enq(r);
        @(negedge clock);
        chk("enq_ready", 32'(bus.enq_ready), 32'd1);
        cyc();
    endtask

    task automatic idle(input int n);
        bus.enq_valid = 1'b0;
        repeat (n) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.enq_valid       = 1'b0;
        bus.enq_robid       = '0;
        bus.enq_payload     = '0;
        bus.int_instr_ready = 1'b0;
        flush_valid         = 1'b0;
        flush_robid         = '0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_valid", 32'(bus.int_instr_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_enq_ready", 32'(bus.enq_ready), 32'd0);
        reset_n = 1'b1;
        cyc();

        // back-to-back enqueue with the execution unit always ready
        bus.int_instr_ready = 1'b1;
        drive_enq(7'h05);
        @(negedge clock);
        chk("t1_enq_ready", 32'(bus.enq_ready), 32'd1);
        chk("t1_no_bypass", 32'(bus.int_instr_valid), 32'd0);
        cyc();
        drive_enq(7'h06);
        @(negedge clock);
        chk("t1_valid_next", 32'(bus.int_instr_valid), 32'd1);
        cyc();
        drive_enq(7'h07);
        cyc();
        idle(1);
        @(negedge clock);
        chk("t1_count", 32'(count), 32'd0);
        chk("t1_drained", 32'(exp_q.size()), 32'd0);
        bus.int_instr_ready = 1'b0;
        cyc();

        // fill to full, hold a 9th offer, free one slot
        for (int i = 0; i < 8; i++)
            enq_one(7'(8 + i));
        bus.enq_valid = 1'b0;
        @(negedge clock);
        chk("t2_count_full", 32'(count), 32'd8);
        chk("t2_enq_ready_full", 32'(bus.enq_ready), 32'd0);
        cyc();
        bus.enq_valid   = 1'b1;
        bus.enq_robid   = 7'h18;
        bus.enq_payload = pay(7'h18);
        @(negedge clock);
        chk("t2_ninth_held", 32'(bus.enq_ready), 32'd0);
        cyc();
        bus.int_instr_ready = 1'b1;
        @(negedge clock);
        chk("t2_full_deq_ready", 32'(bus.enq_ready), 32'd0);
        cyc();
        bus.int_instr_ready = 1'b0;
        exp_q.push_back(exp_t'{r: 7'h18, p: pay(7'h18)});
        @(negedge clock);
        chk("t2_count_7", 32'(count), 32'd7);
        chk("t2_enq_ready_rise", 32'(bus.enq_ready), 32'd1);
        cyc();
        bus.enq_valid = 1'b0;
        @(negedge clock);
        chk("t2_count_refill", 32'(count), 32'd8);
        cyc();
        bus.int_instr_ready = 1'b1;
        idle(8);
        @(negedge clock);
        chk("t2_count_drain", 32'(count), 32'd0);
        bus.int_instr_ready = 1'b0;
        cyc();

        // flush mid-queue: 0x13,0x14 die
        for (int i = 0; i < 5; i++)
            enq_one(7'(8'h10 + i));
        bus.enq_valid = 1'b0;
        flush_valid   = 1'b1;
        flush_robid   = 7'h12;
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        @(negedge clock);
        chk("t3_flush_enq_ready", 32'(bus.enq_ready), 32'd0);
        chk("t3_head_alive", 32'(bus.int_instr_valid), 32'd1);
        cyc();
        flush_valid = 1'b0;
        bus.int_instr_ready = 1'b1;
        @(negedge clock);
        chk("t3_count", 32'(count), 32'd3);
        cyc();
        idle(2);
        @(negedge clock);
        chk("t3_count_drain", 32'(count), 32'd0);
        bus.int_instr_ready = 1'b0;
        cyc();

        // wrap-bit ordering, then kill everything
        enq_one(7'h3E);
        enq_one(7'h3F);
        enq_one(7'h40);
        enq_one(7'h41);
        bus.enq_valid = 1'b0;
        flush_valid   = 1'b1;
        flush_robid   = 7'h3F;
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        @(negedge clock);
        chk("t4_head_alive", 32'(bus.int_instr_valid), 32'd1);
        cyc();
        flush_robid = 7'h3D;
        bus.int_instr_ready = 1'b1;
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        @(negedge clock);
        chk("t4_wrap_count", 32'(count), 32'd2);
        chk("t4_kill_valid", 32'(bus.int_instr_valid), 32'd0);
        cyc();
        flush_valid = 1'b0;
        @(negedge clock);
        chk("t4_all_killed", 32'(count), 32'd0);
        chk("t4_valid_after", 32'(bus.int_instr_valid), 32'd0);
        bus.int_instr_ready = 1'b0;
        cyc();

        // flush with head dequeue and refused enqueue
        for (int i = 0; i < 5; i++)
            enq_one(7'(8'h20 + i));
        bus.enq_valid   = 1'b1;
        bus.enq_robid   = 7'h25;
        bus.enq_payload = pay(7'h25);
        flush_valid     = 1'b1;
        flush_robid     = 7'h22;
        bus.int_instr_ready = 1'b1;
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        @(negedge clock);
        chk("t5_enq_refused", 32'(bus.enq_ready), 32'd0);
        chk("t5_head_valid", 32'(bus.int_instr_valid), 32'd1);
        cyc();
        bus.enq_valid = 1'b0;
        flush_valid   = 1'b0;
        bus.int_instr_ready = 1'b0;
        @(negedge clock);
        chk("t5_count", 32'(count), 32'd2);
        cyc();
        bus.int_instr_ready = 1'b1;
        idle(2);
        @(negedge clock);
        chk("t5_count_drain", 32'(count), 32'd0);
        chk("t5_drained", 32'(exp_q.size()), 32'd0);
        bus.int_instr_ready = 1'b0;
        cyc();

        // asynchronous reset mid-cycle
        for (int i = 0; i < 5; i++)
            enq_one(7'(8'h30 + i));
        bus.enq_valid = 1'b0;
        @(negedge clock);
        chk("t6_count_5", 32'(count), 32'd5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(bus.int_instr_valid), 32'd0);
        chk("t6_async_count", 32'(count), 32'd0);
        chk("t6_async_enq_ready", 32'(bus.enq_ready), 32'd0);
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        cyc();
        bus.int_instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("t6_no_stale", 32'(bus.int_instr_valid), 32'd0);
            cyc();
        end
        @(negedge clock);
        chk("t6_count_after", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
